// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: arbiter state encoding and default starvation limit shared by ram_arbiter and ram_arb_starve.
package ram_arb_pkg;
  typedef enum logic {ARB_NORM, ARB_FORCE} arb_state_e;
  localparam int STARVE_MAX_DEF = 15;
endpackage

// File: rtl/ram_arb_starve.sv
// ram_arb_starve: aux wait counter and one-cycle FORCE state; only instantiated when RAM_ARB_STARVE_EN is defined.
module ram_arb_starve
  import ram_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic aux_req,
  input  logic aux_gnt,
  output logic force_on
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  arb_state_e state_d, state_q;
  logic [CNT_W-1:0] wait_cnt_d, wait_cnt_q;
  logic waiting;
  assign force_on = state_q == ARB_FORCE;
  assign waiting = aux_req & ~aux_gnt;
  always_comb begin
    state_d = (!force_on && waiting && wait_cnt_q == CNT_MAX) ? ARB_FORCE : ARB_NORM;
    wait_cnt_d = (force_on || aux_gnt) ? '0 :
                 (waiting && wait_cnt_q != CNT_MAX) ? wait_cnt_q + 1'b1 : wait_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_NORM;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: CPU-priority mux of CPU and aux masters onto one synchronous RAM port.
// Define RAM_ARB_STARVE_EN to add the starvation guard that forces a one-cycle aux grant.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  logic force_on, aux_sel, aux_rvalid_d, aux_rvalid_q;
`ifdef RAM_ARB_STARVE_EN
  ram_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .aux_req  (aux_req),
    .aux_gnt  (aux_gnt),
    .force_on (force_on)
  );
`else
  assign force_on = 1'b0 & (STARVE_MAX > 0);
`endif
  // FORCE takes the port even if the aux request vanished, leaving the RAM idle that cycle
  always_comb begin
    aux_sel = force_on | ~cpu_en;
    aux_gnt = aux_sel & aux_req;
    cpu_stall = force_on;
    ram_en = aux_sel ? aux_req : 1'b1;
    ram_we = aux_sel ? aux_we : cpu_we;
    ram_addr = aux_sel ? aux_addr : cpu_addr;
    ram_wdata = aux_sel ? aux_wdata : cpu_wdata;
    aux_rvalid_d = aux_gnt & ~aux_we;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) aux_rvalid_q <= 1'b0;
    else aux_rvalid_q <= aux_rvalid_d;
  end
  assign aux_rvalid = aux_rvalid_q;
  assign cpu_rdata = ram_rdata;
  assign aux_rdata = ram_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a cycle-level reference model.
module tb_ram_arbiter;
  localparam int SM = 3;
`ifdef RAM_ARB_STARVE_EN
  localparam int FORCE_K = SM + 1;
  localparam int STARVE_CYC = SM + 3;
`else
  localparam int FORCE_K = -1;
  localparam int STARVE_CYC = 100;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_en, cpu_we, aux_req, aux_we;
  logic [31:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic [31:0] cpu_rdata, aux_rdata, ram_addr, ram_wdata, ram_rdata;
  logic cpu_stall, aux_gnt, aux_rvalid, ram_en, ram_we;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int i);
    return (i == 'h40) ? 32'hDEADBEEF : {8'(i), 8'(i ^ 'h5a), 8'(255 - i), 8'(i * 7)};
  endfunction

  // RAM behind the arbiter: one-cycle read latency, reloaded while in reset
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!rst_n) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    else if (ram_en) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      else ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  logic [31:0] ref_mem [256];
  logic [31:0] m_rdata;
  bit m_force, m_rvalid, m_cpu_rd, m_stall, m_gnt;
  int m_wait;
  int n_vec = 0, n_bad = 0;
  logic r_ce = 0, r_cw = 0, r_ar = 0, r_aw = 0;
  logic [31:0] r_ca = 0, r_cd = 0, r_aa = 0, r_ad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_force = 0; m_wait = 0; m_rvalid = 0; m_cpu_rd = 0; m_stall = 0; m_gnt = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic drive(input logic ce, cw, input logic [31:0] ca, cd,
                       input logic ar, aw, input logic [31:0] aa, ad);
    cpu_en = ce; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    aux_req = ar; aux_we = aw; aux_addr = aa; aux_wdata = ad;
  endtask

  // one bus cycle: drive at negedge, compare, then advance the model past the next posedge
  task automatic apply(input logic ce, cw, input logic [31:0] ca, cd,
                       input logic ar, aw, input logic [31:0] aa, ad);
    bit aux_path, e_gnt, e_en, e_we;
    logic [31:0] e_addr, e_wd;
    @(negedge clk);
    drive(ce, cw, ca, cd, ar, aw, aa, ad);
    #1;
    chk("aux_rvalid", aux_rvalid, m_rvalid);
    if (m_rvalid || m_cpu_rd) begin
      chk("cpu_rdata", cpu_rdata, m_rdata);
      chk("aux_rdata", aux_rdata, m_rdata);
    end
    aux_path = m_force || !ce;
    e_gnt = ar && aux_path;
    e_en = aux_path ? ar : 1'b1;
    e_we = aux_path ? aw : cw;
    e_addr = aux_path ? aa : ca;
    e_wd = aux_path ? ad : cd;
    chk("aux_gnt", aux_gnt, e_gnt);
    chk("cpu_stall", cpu_stall, m_force);
    chk("ram_en", ram_en, e_en);
    if (e_en) begin
      chk("ram_we", ram_we, e_we);
      chk("ram_addr", ram_addr, e_addr);
      if (e_we) chk("ram_wdata", ram_wdata, e_wd);
    end
    m_rvalid = e_gnt && !aw;
    m_cpu_rd = e_en && !aux_path && !cw;
    if (e_en && !e_we) m_rdata = ref_mem[e_addr[7:0]];
    if (e_en && e_we) ref_mem[e_addr[7:0]] = e_wd;
    m_stall = m_force;
    m_gnt = e_gnt;
`ifdef RAM_ARB_STARVE_EN
    // aux is forced in after SM+1 consecutive cycles of waiting
    if (m_force || e_gnt) begin
      m_force = 0;
      m_wait = 0;
    end else if (ar) begin
      m_force = (m_wait == SM);
      m_wait++;
    end
`endif
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic starve_run();
    for (int k = 0; k < STARVE_CYC; k++) begin
      apply(1, 0, 'h30, 0, (FORCE_K < 0) || (k <= FORCE_K), 0, 'h50, 0);
      chk("starve_gnt", aux_gnt, k == FORCE_K);
      chk("starve_stall", cpu_stall, k == FORCE_K);
      chk("starve_addr", ram_addr, (k == FORCE_K) ? 32'h50 : 32'h30);
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", cpu_stall, 0);
    chk("rst_gnt", aux_gnt, 0);
    chk("rst_en", ram_en, 0);
    chk("rst_rvalid", aux_rvalid, 0);
    rst_n = 1;

    apply(0, 0, 0, 0, 1, 0, 'h40, 0);
    chk("auxrd_gnt", aux_gnt, 1);
    chk("auxrd_addr", ram_addr, 'h40);
    idle();
    chk("auxrd_rvalid", aux_rvalid, 1);
    chk("auxrd_data", aux_rdata, 32'hDEADBEEF);

    apply(1, 1, 'h10, 5, 1, 0, 'h44, 0);
    chk("coll_addr", ram_addr, 'h10);
    chk("coll_wdata", ram_wdata, 5);
    chk("coll_gnt", aux_gnt, 0);
    apply(0, 0, 0, 0, 1, 0, 'h44, 0);
    apply(1, 0, 'h10, 0, 0, 0, 0, 0);
    idle();
    chk("cpu_rdback", cpu_rdata, 5);

    apply(0, 0, 0, 0, 1, 1, 'h20, 'hA5);
    chk("auxwr_we", ram_we, 1);
    chk("auxwr_wdata", ram_wdata, 'hA5);
    idle();
    chk("auxwr_rvalid", aux_rvalid, 0);

    starve_run();
    idle();

    for (int k = 0; k <= 4; k++) apply(1, 0, 'h30, 0, 1, 0, 'h50, 0);
    rst_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("midrst_stall", cpu_stall, 0);
    chk("midrst_en", ram_en, 0);
    model_reset();
    @(negedge clk);
    #1;
    chk("midrst_rvalid", aux_rvalid, 0);
    rst_n = 1;
    starve_run();
    idle();

    for (int k = 0; k <= 5; k++) begin
      apply(1, 0, 'h31, 0, k < 4, 0, 'h51, 0);
      chk("drop_en", ram_en, (k == FORCE_K) ? 0 : 1);
      chk("drop_stall", cpu_stall, k == FORCE_K);
    end
    idle();

    for (int n = 0; n < 500; n++) begin
      if (!m_stall) begin
        r_ce = $urandom_range(0, 99) < 60;
        r_cw = 1'($urandom_range(0, 1));
        r_ca = $urandom_range(0, 255);
        r_cd = $urandom;
      end
      if (!r_ar || m_gnt) begin
        r_ar = $urandom_range(0, 99) < 50;
        r_aw = 1'($urandom_range(0, 1));
        r_aa = $urandom_range(0, 255);
        r_ad = $urandom;
      end
      apply(r_ce, r_cw, r_ca, r_cd, r_ar, r_aw, r_aa, r_ad);
    end
    idle();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
